icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache between the fetcher (instruction requester) and ask_memory (byte-serial RAM port that assembles 32-bit words).
- One 32-bit instruction per line.
- Hits are served in 1 cycle, so repeated fetches of loops do not consume the shared memory port needed by the load/store buffer.
- Flushes its in-flight request on has_misbranch. Cached lines are kept on a flush.

Parameters:
- INDEX_BITS, 7, line index width; the cache holds 2^INDEX_BITS lines (128 words, 512 B).
- TAG_BITS, 30-INDEX_BITS, tag width, taken from address bits [31:INDEX_BITS+2].

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; when low, all state and outputs hold.
- has_misbranch  in  1  ROB flush pulse.
- fetch_ask  in  1  fetcher request; held high with fetch_addr stable until inst_ready.
- fetch_addr  in  32  instruction address; bits [1:0] are ignored.
- inst_ready  out  1  one-cycle pulse; inst is valid in that cycle.
- inst  out  32  returned instruction word.
- mem_ask  out  1  fill request to ask_memory; held high until mem_ready.
- mem_addr  out  32  word-aligned fill address.
- mem_ready  in  1  fill data valid (one-cycle pulse).
- mem_inst  in  32  fill data word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, inst_ready=0, inst=0, mem_ask=0, mem_addr=0.
  - All valid bits cleared.
  - Tag and data arrays need no reset.
- All updates happen on posedge clk and only when rdy=1.
- Address split: index=fetch_addr[INDEX_BITS+1:2], tag=fetch_addr[31:INDEX_BITS+2].
- hit = valid[index] && tag_arr[index]==tag, evaluated combinationally from the array read.
- IDLE:
  - fetch_ask && hit → inst<=data_arr[index], inst_ready<=1, go DONE. Hit latency: inst_ready is high the cycle after the ask is sampled.
  - fetch_ask && !hit → mem_ask<=1, mem_addr<={fetch_addr[31:2],2'b00}, latch index and tag, go FILL.
  - No fetch_ask → stay in IDLE.
- FILL:
  - mem_ask stays 1 until mem_ready.
  - On mem_ready: write data_arr/tag_arr at the latched index, set valid, inst<=mem_inst, inst_ready<=1, mem_ask<=0, go DONE.
  - fetch_addr is not re-sampled in FILL.
- DONE:
  - inst_ready<=0, go IDLE.
  - The bubble cycle lets the fetcher drop or change fetch_ask. Throughput is 1 hit per 2 cycles.
- has_misbranch (highest priority, any state):
  - inst_ready<=0, mem_ask<=0, state<=IDLE.
  - A mem_ready arriving in the same cycle is discarded: no array write, valid unchanged.
  - Lines already valid are retained; instruction memory is read-only, so nothing becomes stale.
- Conflict: a miss to an occupied index overwrites that line. There is no victim handling.
- mem_ready outside FILL is ignored.
- rdy=0: no transitions; outputs hold current values, including an inst_ready of 1.
- Async reset mid-FILL: mem_ask drops immediately; the partial fill is lost.

Decomposition:
- Shared defines file: reuse `Addr_Len and `Data_Len. Add `Icache_Index_Len and `Icache_Tag_Len derived from INDEX_BITS.
- State encoding (IDLE=0, FILL=1, DONE=2) is local to icache.
- One sub-module: icache_array.
  - Storage: valid vector with async active-low clear, tag RAM, data RAM.
  - Combinational read port, synchronous write port.
  - Keeps the arrays mappable to distributed RAM.

Test Plan:
1. Cold miss: after reset, fetch_ask=1, fetch_addr=0x00000000 → next cycle mem_ask=1, mem_addr=0x0. Drive mem_ready=1, mem_inst=0x00000013 four cycles later → inst_ready pulses 1 cycle after that with inst=0x00000013, then mem_ask=0.
2. Hit: re-request 0x00000000 → inst_ready=1 one cycle after the ask, inst=0x00000013, mem_ask stays 0 throughout.
3. Conflict: fetch 0x00000200 (index 0, different tag) → miss, fill 0x00100093. Refetch 0x00000000 → miss again (mem_ask=1), proving replacement.
4. Flush during fill: miss on 0x00000040; assert has_misbranch in the same cycle as mem_ready (mem_inst=0xDEADBEEF) → inst_ready stays 0, mem_ask=0 next cycle. Later fetch of 0x00000040 misses again.
5. Stall: in FILL, drop rdy for 3 cycles → mem_ask and state frozen. Raise rdy with mem_ready → normal completion.
6. Async reset mid-FILL: rst=0 between clock edges → mem_ask=0 and inst_ready=0 immediately. After release, a prior hit address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths and helpers for the direct-mapped instruction cache.
package icache_pkg;
  localparam int ADDR_LEN          = 32;
  localparam int DATA_LEN          = 32;
  localparam int ICACHE_INDEX_LEN  = 7;
  localparam int ICACHE_TAG_LEN    = ADDR_LEN - 2 - ICACHE_INDEX_LEN;

  function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
    return {addr[ADDR_LEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write, valid bits cleared by reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_LEN,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_LEN-1:0]   rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_LEN-1:0]   wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [DATA_LEN-1:0] data_arr [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // No reset on tag/data so they map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_arr[wr_idx]  <= wr_tag;
      data_arr[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data  = data_arr[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between fetcher and memory port.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_LEN,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                has_misbranch,
  input  logic                fetch_ask,
  input  logic [ADDR_LEN-1:0] fetch_addr,
  output logic                inst_ready,
  output logic [DATA_LEN-1:0] inst,
  output logic                mem_ask,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic [DATA_LEN-1:0] mem_inst
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  inst_ready_q, inst_ready_d;
  logic [DATA_LEN-1:0]   inst_q, inst_d;
  logic                  mem_ask_q, mem_ask_d;
  logic [ADDR_LEN-1:0]   mem_addr_q, mem_addr_d;
  logic [INDEX_BITS-1:0] fill_idx_q, fill_idx_d;
  logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;

  logic [INDEX_BITS-1:0] fetch_idx_s;
  logic [TAG_BITS-1:0]   fetch_tag_s;
  logic                  rd_valid_s;
  logic [TAG_BITS-1:0]   rd_tag_s;
  logic [DATA_LEN-1:0]   rd_data_s;
  logic                  hit_s;
  logic                  wr_en_s;

  assign fetch_idx_s = fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag_s = fetch_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign hit_s       = rd_valid_s && (rd_tag_s == fetch_tag_s);

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_idx_s),
    .rd_valid(rd_valid_s),
    .rd_tag  (rd_tag_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_idx  (fill_idx_q),
    .wr_tag  (fill_tag_q),
    .wr_data (mem_inst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      mem_ask_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      mem_ask_q    <= mem_ask_d;
      mem_addr_q   <= mem_addr_d;
      fill_idx_q   <= fill_idx_d;
      fill_tag_q   <= fill_tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!rdy) begin
      state_d = state_q;
    end else if (has_misbranch) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_ask) begin
            state_d = hit_s ? ST_DONE : ST_FILL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A misbranch outranks a same-cycle mem_ready, so that fill is dropped unwritten.
  always_comb begin
    inst_ready_d = inst_ready_q;
    inst_d       = inst_q;
    mem_ask_d    = mem_ask_q;
    mem_addr_d   = mem_addr_q;
    fill_idx_d   = fill_idx_q;
    fill_tag_d   = fill_tag_q;
    wr_en_s      = 1'b0;
    if (!rdy) begin
      wr_en_s = 1'b0;
    end else if (has_misbranch) begin
      inst_ready_d = 1'b0;
      mem_ask_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_ask && hit_s) begin
            inst_d       = rd_data_s;
            inst_ready_d = 1'b1;
          end else if (fetch_ask) begin
            mem_ask_d  = 1'b1;
            mem_addr_d = word_align(fetch_addr);
            fill_idx_d = fetch_idx_s;
            fill_tag_d = fetch_tag_s;
          end else begin
            inst_ready_d = 1'b0;
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            wr_en_s      = 1'b1;
            inst_d       = mem_inst;
            inst_ready_d = 1'b1;
            mem_ask_d    = 1'b0;
          end else begin
            mem_ask_d = 1'b1;
          end
        end
        ST_DONE: inst_ready_d = 1'b0;
        default: begin
          inst_ready_d = 1'b0;
          mem_ask_d    = 1'b0;
        end
      endcase
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst       = inst_q;
  assign mem_ask    = mem_ask_q;
  assign mem_addr   = mem_addr_q;
endmodule
